// File: rtl/vvmac_seq.sv
// rtl/vvmac_seq.sv - sequential vector-vector multiply-accumulate with bias, rounding and saturation
//
// Purpose: consumes a stream of Q9.7 activations paired with Q2.14 weights,
// accumulates their products on top of a Q3.14 bias, and emits one rounded,
// saturated Q3.14 result per vector.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   in_valid / in_ready        input beat handshake
//   in_data                    activation, Q9.7 signed
//   in_weight                  weight, Q2.14 signed
//   in_bias                    bias, Q3.14 signed, sampled on the first beat
//   in_last                    final beat of the vector
//   out_valid / out_ready      result handshake
//   out_data                   result, Q3.14 signed
//   out_sat                    result was clipped to the Q3.14 range
//   out_trunc                  vector ended at MAX_LEN beats without in_last

module vvmac_seq #(
  parameter int VVMAC_IN_W  = 16,
  parameter int WEIGHT_W    = 16,
  parameter int VVMAC_OUT_W = 17,
  parameter int ACC_W       = 40,
  parameter int MAX_LEN     = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VVMAC_IN_W-1:0]  in_data,
  input  logic [WEIGHT_W-1:0]    in_weight,
  input  logic [VVMAC_OUT_W-1:0] in_bias,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VVMAC_OUT_W-1:0] out_data,
  output logic                   out_sat,
  output logic                   out_trunc
);

  localparam int PROD_W = VVMAC_IN_W + WEIGHT_W;
  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  // Bias is Q3.14; shifting left by 7 aligns it with the 21 fractional bits
  // of the product.
  localparam int BIAS_SHIFT = 7;

  localparam logic signed [ACC_W-1:0] RND   = {{(ACC_W-7){1'b0}}, 7'd64};
  localparam logic signed [ACC_W-1:0] Q_MAX =
    {{(ACC_W-VVMAC_OUT_W+1){1'b0}}, {(VVMAC_OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_MIN =
    {{(ACC_W-VVMAC_OUT_W+1){1'b1}}, {(VVMAC_OUT_W-1){1'b0}}};
  localparam logic [VVMAC_OUT_W-1:0] OUT_MAX = {1'b0, {(VVMAC_OUT_W-1){1'b1}}};
  localparam logic [VVMAC_OUT_W-1:0] OUT_MIN = {1'b1, {(VVMAC_OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, OUT} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         beat_idx;
  logic                     accept;
  logic                     beat_cut;
  logic                     beat_end;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  bias_ext;

  // S1 registers
  logic                     p1_valid;
  logic                     p1_last;
  logic                     p1_trunc;
  logic signed [PROD_W-1:0] p1_prod;
  logic signed [ACC_W-1:0]  p1_prod_ext;

  // S2 registers
  logic signed [ACC_W-1:0]  acc;
  logic                     s2_done;
  logic                     s2_trunc;

  // S3 combinational round/saturate
  logic signed [ACC_W-1:0]  acc_shift;
  logic [VVMAC_OUT_W-1:0]   res_data;
  logic                     res_sat;

  assign accept = in_valid && in_ready;

  // In IDLE the counter still holds the previous vector's length, so the
  // beat being accepted there is always beat 0.
  assign beat_idx = (state == IDLE) ? '0 : cnt;
  assign beat_cut = (beat_idx == CNT_W'(MAX_LEN - 1));
  assign beat_end = in_last || beat_cut;

  assign prod        = $signed(in_data) * $signed(in_weight);
  assign bias_ext    = {{(ACC_W-VVMAC_OUT_W-BIAS_SHIFT){in_bias[VVMAC_OUT_W-1]}},
                        in_bias, {BIAS_SHIFT{1'b0}}};
  assign p1_prod_ext = {{(ACC_W-PROD_W){p1_prod[PROD_W-1]}}, p1_prod};

  // Round half up, then drop the 7 extra fractional bits.
  assign acc_shift = (acc + RND) >>> 7;

  always_comb begin
    res_data = acc_shift[VVMAC_OUT_W-1:0];
    res_sat  = 1'b0;
    if (acc_shift > Q_MAX) begin
      res_data = OUT_MAX;
      res_sat  = 1'b1;
    end else if (acc_shift < Q_MIN) begin
      res_data = OUT_MIN;
      res_sat  = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = beat_end ? FLUSH : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (accept && beat_end) state_nxt = FLUSH;
      end
      FLUSH: begin
        // s2_done marks the cycle the final sum sits in acc; the result
        // register is loaded on the same edge that enters OUT.
        if (s2_done) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      p1_valid  <= 1'b0;
      p1_last   <= 1'b0;
      p1_trunc  <= 1'b0;
      p1_prod   <= '0;
      acc       <= '0;
      s2_done   <= 1'b0;
      s2_trunc  <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      state <= state_nxt;

      p1_valid <= accept;
      p1_last  <= accept && beat_end;
      p1_trunc <= accept && beat_cut && !in_last;
      if (accept) begin
        p1_prod <= prod;
        cnt     <= beat_idx + CNT_W'(1);
      end

      // The pipeline is always empty when a first beat arrives (input is
      // blocked until the previous result is taken), so the bias load never
      // collides with a pending product.
      if (accept && state == IDLE) begin
        acc <= bias_ext;
      end else if (p1_valid) begin
        acc <= acc + p1_prod_ext;
      end
      s2_done  <= p1_valid && p1_last;
      s2_trunc <= p1_trunc;

      if (s2_done) begin
        out_data  <= res_data;
        out_sat   <= res_sat;
        out_trunc <= s2_trunc;
      end
    end
  end

endmodule
